// File: rtl/guess_code_engine.sv
// rtl/guess_code_engine.sv - two-player code-guessing controller with edge-detected key entry
// Player A stores a secret, player B gets MAX_TURNS guesses scored position by position.
module guess_code_engine #(
  parameter  int NUM_KEYS  = 4,
  parameter  int MAX_LEN   = 7,
  parameter  int MIN_LEN   = 4,
  parameter  int MAX_TURNS = 3,
  localparam int KW        = $clog2(NUM_KEYS),
  localparam int LW        = $clog2(MAX_LEN + 1),
  localparam int TW        = $clog2(MAX_TURNS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                enter,
  input  logic                clear,
  output logic [2:0]          phase,
  output logic [LW-1:0]       len_a,
  output logic [LW-1:0]       len_b,
  output logic [TW-1:0]       turns_used,
  output logic [MAX_LEN-1:0]  match_mask,
  output logic                win,
  output logic                lose,
  output logic                equal,
  output logic                bigger,
  output logic                smaller,
  output logic                guess_done,
  output logic                entry_err
);

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_ENTER_B = 2'd1,
    S_WON     = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  localparam logic [LW-1:0]       MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0]       MIN_L = LW'(MIN_LEN);
  localparam logic [TW-1:0]       MAX_T = TW'(MAX_TURNS);
  localparam logic [NUM_KEYS-1:0] ONE_K = NUM_KEYS'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_KEYS-1:0]  r_key_q;
  logic                 r_enter_q;
  logic [LW-1:0]        r_len_a;
  logic [LW-1:0]        r_len_b;
  logic [TW-1:0]        r_turns;
  logic [MAX_LEN-1:0]   r_mask;
  logic                 r_win;
  logic                 r_lose;
  logic                 r_equal;
  logic                 r_bigger;
  logic                 r_smaller;
  logic                 r_guess_done;
  logic                 r_entry_err;
  logic [KW-1:0]        r_sec [MAX_LEN];
  logic [KW-1:0]        r_gs  [MAX_LEN];

  logic [NUM_KEYS-1:0]  w_press;
  logic                 w_enter_p;
  logic                 w_single;
  logic                 w_multi;
  logic [KW-1:0]        w_sym;
  logic [MAX_LEN-1:0]   w_mask;
  logic                 w_win_now;
  logic [TW-1:0]        w_turns_inc;
  logic                 w_store_a;
  logic                 w_store_b;
  logic                 w_eval;
  logic                 w_err;

  assign w_press     = key & ~r_key_q;
  assign w_enter_p   = enter & ~r_enter_q;
  assign w_multi     = (w_press & (w_press - ONE_K)) != '0;
  assign w_single    = (w_press != '0) && !w_multi;
  assign w_turns_inc = r_turns + TW'(1);
  assign w_win_now   = &w_mask;

  always_comb begin
    w_sym = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_press[k]) w_sym = KW'(k);
    end
  end

  // Positions beyond both lengths count as matches so a full mask means a win.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    localparam logic [LW-1:0] IDX = LW'(i);
    assign w_mask[i] = ((IDX < r_len_a) && (IDX < r_len_b) && (r_sec[i] == r_gs[i])) ||
                       ((IDX >= r_len_a) && (IDX >= r_len_b));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_ENTER_A;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store_a   = 1'b0;
    w_store_b   = 1'b0;
    w_eval      = 1'b0;
    w_err       = 1'b0;
    if (clear) begin
      w_state_nxt = S_ENTER_A;
    end else begin
      case (r_state)
        S_ENTER_A: begin
          if (r_len_a == MAX_L) begin
            w_state_nxt = S_ENTER_B;
          end else if (w_enter_p) begin
            if (r_len_a >= MIN_L) w_state_nxt = S_ENTER_B;
            else                  w_err = 1'b1;
          end else if (w_multi) begin
            w_err = 1'b1;
          end else if (w_single) begin
            w_store_a = 1'b1;
          end
        end
        S_ENTER_B: begin
          if (w_enter_p) begin
            if (r_len_b < MIN_L) begin
              w_err = 1'b1;
            end else begin
              w_eval = 1'b1;
              if (w_win_now)                 w_state_nxt = S_WON;
              else if (w_turns_inc == MAX_T) w_state_nxt = S_LOST;
            end
          end else if (w_multi) begin
            w_err = 1'b1;
          end else if (w_single) begin
            if (r_len_b == MAX_L) w_err = 1'b1;
            else                  w_store_b = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_q      <= '0;
      r_enter_q    <= 1'b0;
      r_len_a      <= '0;
      r_len_b      <= '0;
      r_turns      <= '0;
      r_mask       <= '0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_equal      <= 1'b0;
      r_bigger     <= 1'b0;
      r_smaller    <= 1'b0;
      r_guess_done <= 1'b0;
      r_entry_err  <= 1'b0;
    end else begin
      r_key_q   <= key;
      r_enter_q <= enter;
      if (clear) begin
        r_len_a      <= '0;
        r_len_b      <= '0;
        r_turns      <= '0;
        r_mask       <= '0;
        r_win        <= 1'b0;
        r_lose       <= 1'b0;
        r_equal      <= 1'b0;
        r_bigger     <= 1'b0;
        r_smaller    <= 1'b0;
        r_guess_done <= 1'b0;
        r_entry_err  <= 1'b0;
      end else begin
        r_guess_done <= w_eval;
        r_entry_err  <= w_err;
        if (w_store_a) r_len_a <= r_len_a + LW'(1);
        if (w_store_b) r_len_b <= r_len_b + LW'(1);
        if (w_eval) begin
          r_mask    <= w_mask;
          r_equal   <= (r_len_b == r_len_a);
          r_bigger  <= (r_len_b < r_len_a);
          r_smaller <= (r_len_b > r_len_a);
          if (w_win_now) begin
            r_win <= 1'b1;
          end else begin
            r_turns <= w_turns_inc;
            if (w_turns_inc == MAX_T) r_lose  <= 1'b1;
            else                      r_len_b <= '0;
          end
        end
      end
    end
  end

  // Symbol storage is gated by the length counters, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (w_store_a && (r_len_a == LW'(i))) r_sec[i] <= w_sym;
      if (w_store_b && (r_len_b == LW'(i))) r_gs[i]  <= w_sym;
    end
  end

  assign phase      = {1'b0, r_state};
  assign len_a      = r_len_a;
  assign len_b      = r_len_b;
  assign turns_used = r_turns;
  assign match_mask = r_mask;
  assign win        = r_win;
  assign lose       = r_lose;
  assign equal      = r_equal;
  assign bigger     = r_bigger;
  assign smaller    = r_smaller;
  assign guess_done = r_guess_done;
  assign entry_err  = r_entry_err;

endmodule
